// File: rtl/smp8_pkg.sv
// Shared definitions for the SMP8 boot path.
//   loader_state_e : program loader FSM encoding (3-bit)
//   IMEM_DEPTH     : instruction memory depth in words
//   DW / AW        : instruction width and imem address width
package smp8_pkg;

    localparam int unsigned DW         = 8;
    localparam int unsigned AW         = 6;
    localparam int unsigned IMEM_DEPTH = 64;

    typedef enum logic [2:0] {
        StLen  = 3'd0,
        StData = 3'd1,
        StCsum = 3'd2,
        StDone = 3'd3,
        StErr  = 3'd4
    } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot-time program loader for the SMP8 instruction memory.
// Accepts a framed byte stream (length, N program bytes, checksum) over a
// valid/ready handshake, writes the program bytes into imem from address 0,
// and releases the core from reset only once a frame loads with a good
// checksum.
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      asynchronous active-high reset
//   start_i      one-cycle pulse: abort any frame and begin a new load
//   in_valid_i   source presents a byte on in_data_i
//   in_data_i    stream byte
//   in_ready_o   loader accepts a byte this cycle
//   mem_we_o     imem write enable
//   mem_addr_o   imem write address
//   mem_wd_o     imem write data
//   cpu_reset_o  core reset, 1 = core held in reset
//   load_done_o  last frame loaded with a good checksum
//   load_err_o   last frame rejected
module imem_loader
    import smp8_pkg::*;
#(
    parameter int unsigned AW = smp8_pkg::AW,
    parameter int unsigned DW = smp8_pkg::DW
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          in_ready_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wd_o,
    output logic          cpu_reset_o,
    output logic          load_done_o,
    output logic          load_err_o
);

    localparam int unsigned Depth = 2 ** AW;

    loader_state_e state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] sum_q, sum_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          xfer;
    logic          len_ok;
    logic [DW-1:0] sum_next;

    // Ready is forced low while reset is asserted, not just after the edge.
    assign in_ready_o  = ~reset_i & ((state_q == StLen) | (state_q == StData) |
                                     (state_q == StCsum));
    assign xfer        = in_valid_i & in_ready_o;
    // start discards a coincident byte, so it must also suppress the write.
    assign mem_we_o    = ~reset_i & (state_q == StData) & in_valid_i & ~start_i;
    assign mem_addr_o  = addr_q;
    assign mem_wd_o    = in_data_i;
    assign cpu_reset_o = cpu_reset_q;
    assign load_done_o = done_q;
    assign load_err_o  = err_q;

    assign len_ok   = (in_data_i != '0) && (32'(in_data_i) <= 32'(Depth));
    assign sum_next = sum_q + in_data_i;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        err_d       = err_q;

        if (start_i) begin
            state_d     = StLen;
            addr_d      = '0;
            cnt_d       = '0;
            sum_d       = '0;
            cpu_reset_d = 1'b1;
            done_d      = 1'b0;
            err_d       = 1'b0;
        end else if (xfer) begin
            unique case (state_q)
                StLen: begin
                    if (len_ok) begin
                        cnt_d   = in_data_i[AW:0];
                        addr_d  = '0;
                        sum_d   = '0;
                        state_d = StData;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
                StData: begin
                    // Saturate at the top word: a 64-byte frame must not wrap to 0.
                    if (addr_q != AW'(Depth - 1)) begin
                        addr_d = addr_q + AW'(1);
                    end
                    cnt_d = cnt_q - (AW + 1)'(1);
                    sum_d = sum_next;
                    if (cnt_q == (AW + 1)'(1)) begin
                        state_d = StCsum;
                    end
                end
                StCsum: begin
                    if (sum_next == '0) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StLen;
            addr_q      <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule
